// File: rtl/conv5x5_pass_sched.sv
// Pass scheduler for the shared 5x5 convolution datapath: streams one image per filter,
// gates the window strobe, tags results. Optional perf counters: `CONV_SCHED_PERF_EN.
module conv5x5_pass_sched #(
  parameter int IMG_W       = 28,
  parameter int IMG_H       = 28,
  parameter int KSIZE       = 5,
  parameter int NUM_FILTERS = 6,
  parameter int COORD_BITS  = 8,
  parameter int FILT_BITS   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  output logic                  win_valid,
  output logic [FILT_BITS-1:0]  kernel_sel,
  input  logic                  conv_valid,
  output logic                  out_we,
  output logic [COORD_BITS-1:0] out_row,
  output logic [COORD_BITS-1:0] out_col,
  output logic [FILT_BITS-1:0]  out_filt
`ifdef CONV_SCHED_PERF_EN
  ,
  output logic [31:0]           perf_cycles,
  output logic [31:0]           perf_stall
`endif
);

  localparam int OUT_W     = IMG_W - KSIZE + 1;
  localparam int OUT_H     = IMG_H - KSIZE + 1;
  localparam int OUT_TOTAL = OUT_W * OUT_H;
  localparam int CNT_BITS  = 2 * COORD_BITS;

  localparam logic [COORD_BITS-1:0] LAST_COL     = COORD_BITS'(IMG_W - 1);
  localparam logic [COORD_BITS-1:0] LAST_ROW     = COORD_BITS'(IMG_H - 1);
  localparam logic [COORD_BITS-1:0] WIN_MIN      = COORD_BITS'(KSIZE - 1);
  localparam logic [COORD_BITS-1:0] OUT_LAST_COL = COORD_BITS'(IMG_W - KSIZE);
  localparam logic [CNT_BITS-1:0]   OUT_LAST_CNT = CNT_BITS'(OUT_TOTAL - 1);
  localparam logic [FILT_BITS-1:0]  LAST_FILT    = FILT_BITS'(NUM_FILTERS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next_state;

  logic [COORD_BITS-1:0] r_in_row;
  logic [COORD_BITS-1:0] r_in_col;
  logic [COORD_BITS-1:0] r_out_row;
  logic [COORD_BITS-1:0] r_out_col;
  logic [CNT_BITS-1:0]   r_out_cnt;
  logic [FILT_BITS-1:0]  r_kernel_sel;
  logic                  r_win_valid;

  logic                  w_accept;
  logic                  w_xfer;
  logic                  w_last_pix;
  logic                  w_win;
  logic                  w_result;
  logic                  w_pass_end;
  logic                  w_last_filt;

  assign w_accept    = (r_state == S_IDLE) && start;
  assign w_xfer      = (r_state == S_RUN) && pix_valid;
  assign w_last_pix  = w_xfer && (r_in_row == LAST_ROW) && (r_in_col == LAST_COL);
  assign w_win       = w_xfer && (r_in_row >= WIN_MIN) && (r_in_col >= WIN_MIN);
  assign w_result    = conv_valid && ((r_state == S_RUN) || (r_state == S_DRAIN));
  // The pass only ends once every window of it has come back out of the datapath.
  assign w_pass_end  = (r_state == S_DRAIN) && conv_valid && (r_out_cnt == OUT_LAST_CNT);
  assign w_last_filt = (r_kernel_sel == LAST_FILT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next_state = S_RUN;
      S_RUN:   if (w_last_pix) w_next_state = S_DRAIN;
      S_DRAIN: if (w_pass_end) w_next_state = w_last_filt ? S_DONE : S_RUN;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (r_state != S_IDLE);
    done      = (r_state == S_DONE);
    pix_ready = (r_state == S_RUN);
    out_we    = w_result;
  end

  // kernel_sel moves only at a pass end, after the drain, so in-flight windows keep their kernel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_row     <= '0;
      r_in_col     <= '0;
      r_out_row    <= '0;
      r_out_col    <= '0;
      r_out_cnt    <= '0;
      r_kernel_sel <= '0;
      r_win_valid  <= 1'b0;
    end else begin
      r_win_valid <= w_win;
      if (w_accept) begin
        r_in_row     <= '0;
        r_in_col     <= '0;
        r_out_row    <= '0;
        r_out_col    <= '0;
        r_out_cnt    <= '0;
        r_kernel_sel <= '0;
      end else begin
        if (w_xfer) begin
          if (r_in_col == LAST_COL) begin
            r_in_col <= '0;
            r_in_row <= r_in_row + 1'b1;
          end else begin
            r_in_col <= r_in_col + 1'b1;
          end
        end
        if (w_pass_end) begin
          r_in_row  <= '0;
          r_in_col  <= '0;
          r_out_row <= '0;
          r_out_col <= '0;
          r_out_cnt <= '0;
          if (!w_last_filt) begin
            r_kernel_sel <= r_kernel_sel + 1'b1;
          end
        end else if (w_result) begin
          r_out_cnt <= r_out_cnt + 1'b1;
          if (r_out_col == OUT_LAST_COL) begin
            r_out_col <= '0;
            r_out_row <= r_out_row + 1'b1;
          end else begin
            r_out_col <= r_out_col + 1'b1;
          end
        end
      end
    end
  end

  assign win_valid  = r_win_valid;
  assign kernel_sel = r_kernel_sel;
  assign out_filt   = r_kernel_sel;
  assign out_row    = r_out_row;
  assign out_col    = r_out_col;

`ifdef CONV_SCHED_PERF_EN
  logic [31:0] r_perf_cycles;
  logic [31:0] r_perf_stall;

  // Both counters saturate and simply stop moving once the scheduler is back in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_cycles <= '0;
      r_perf_stall  <= '0;
    end else if (w_accept) begin
      r_perf_cycles <= '0;
      r_perf_stall  <= '0;
    end else begin
      if ((r_state != S_IDLE) && (r_perf_cycles != '1)) begin
        r_perf_cycles <= r_perf_cycles + 1'b1;
      end
      if ((r_state == S_RUN) && !pix_valid && (r_perf_stall != '1)) begin
        r_perf_stall <= r_perf_stall + 1'b1;
      end
    end
  end

  assign perf_cycles = r_perf_cycles;
  assign perf_stall  = r_perf_stall;
`endif

endmodule

// File: tb/tb_conv5x5_pass_sched.sv
// Directed bench for conv5x5_pass_sched at 6x6, two filters, with a 3-cycle datapath model.
module tb_conv5x5_pass_sched;

  localparam int IW   = 6;
  localparam int IH   = 6;
  localparam int NF   = 2;
  localparam int PIX  = IW * IH;
  localparam int NRES = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       pix_valid = 1'b0;
  logic       inject = 1'b0;
  logic       busy, done, pix_ready, win_valid, conv_valid, out_we;
  logic [2:0] kernel_sel, out_filt;
  logic [7:0] out_row, out_col;
`ifdef CONV_SCHED_PERF_EN
  logic [31:0] perf_cycles, perf_stall;
`endif

  conv5x5_pass_sched #(
    .IMG_W(IW), .IMG_H(IH), .KSIZE(5), .NUM_FILTERS(NF), .COORD_BITS(8), .FILT_BITS(3)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .win_valid(win_valid),
    .kernel_sel(kernel_sel), .conv_valid(conv_valid), .out_we(out_we),
    .out_row(out_row), .out_col(out_col), .out_filt(out_filt)
`ifdef CONV_SCHED_PERF_EN
    , .perf_cycles(perf_cycles), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  // Datapath model: win_valid in cycle t+1 comes back as conv_valid in cycle t+4.
  logic [2:0] dpPipe = '0;
  always @(posedge clk) dpPipe <= {dpPipe[1:0], win_valid};
  assign conv_valid = dpPipe[2] | inject;

  int cyc = 0;
  int base = 0;
  bit toggleMode = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pixel source: continuous, or valid only on odd cycles counted from the start cycle.
  always @(posedge clk) begin
    #1;
    pix_valid = toggleMode ? (((cyc - base) & 1) == 1) : 1'b1;
  end

  int compared = 0;
  int mismatched = 0;

  bit         monEn = 1'b0;
  int         rel;
  int         xIdx, pIdx, resN, winCnt, winErr, filtErr, doneCyc, curGap, firstGap;
  logic       expWinNext, busyAfter;
  logic [2:0] kFirst0, kFirst1;
  logic [2:0] resF [16];
  logic [7:0] resR [16];
  logic [7:0] resC [16];

  // Observes every cycle and keeps an independent raster model of the window condition.
  always @(negedge clk) begin
    if (monEn) begin
      rel = cyc - base;
      if (win_valid !== expWinNext) winErr++;
      if (win_valid) winCnt++;
      expWinNext = 1'b0;
      if (pix_valid && pix_ready) begin
        pIdx = xIdx % PIX;
        expWinNext = ((pIdx / IW) >= 4) && ((pIdx % IW) >= 4);
        if (xIdx == 0) kFirst0 = kernel_sel;
        if (xIdx == PIX) kFirst1 = kernel_sel;
        xIdx++;
      end
      if (out_we) begin
        if (resN < 16) begin
          resF[resN] = out_filt;
          resR[resN] = out_row;
          resC[resN] = out_col;
        end
        resN++;
        if (out_filt !== kernel_sel) filtErr++;
      end
      if (done && doneCyc < 0) doneCyc = rel;
      if (doneCyc >= 0 && rel == doneCyc + 1) busyAfter = busy;
      if (busy && !pix_ready && !done) begin
        curGap++;
      end else if (curGap > 0) begin
        if (firstGap < 0) firstGap = curGap;
        curGap = 0;
      end
    end
  end

  typedef struct {
    logic [2:0] f;
    logic [7:0] r;
    logic [7:0] c;
  } res_t;
  res_t expTab [NRES];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit tog, input bit glitch, input int rstAt);
    bit finished;
    finished   = 1'b0;
    toggleMode = tog;
    xIdx = 0; resN = 0; winCnt = 0; winErr = 0; filtErr = 0;
    doneCyc = -1; curGap = 0; firstGap = -1;
    expWinNext = 1'b0; busyAfter = 1'bx; kFirst0 = 'x; kFirst1 = 'x;
    @(posedge clk); #1;
    start = 1'b1;
    base  = cyc;
    monEn = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 400 && !finished; k++) begin
      @(posedge clk); #1;
      start = glitch && (cyc - base == 10);
      if (rstAt > 0 && cyc - base == rstAt) begin
        rst = 1'b1;
        finished = 1'b1;
      end
      if (doneCyc >= 0 && cyc - base > doneCyc + 1) finished = 1'b1;
    end
    start = 1'b0;
    @(negedge clk);
    monEn = 1'b0;
  endtask

  task automatic checkRun(input string tag, input int expDone);
    checkOutput({tag, "_resCount"}, resN, NRES);
    for (int i = 0; i < NRES; i++) begin
      checkOutput($sformatf("%s_res%0d", tag, i),
                  {13'd0, resF[i], resR[i], resC[i]},
                  {13'd0, expTab[i].f, expTab[i].r, expTab[i].c});
    end
    checkOutput({tag, "_doneCycle"}, doneCyc, expDone);
    checkOutput({tag, "_busyAfterDone"}, {31'd0, busyAfter}, 0);
    checkOutput({tag, "_winCount"}, winCnt, NRES);
    checkOutput({tag, "_winGating"}, winErr, 0);
    checkOutput({tag, "_filtEqKsel"}, filtErr, 0);
    checkOutput({tag, "_kselPass0"}, {29'd0, kFirst0}, 0);
    checkOutput({tag, "_kselPass1"}, {29'd0, kFirst1}, 1);
    checkOutput({tag, "_drainGap"}, firstGap, 4);
  endtask

  function automatic logic [31:0] allOutputs();
    return {8'd0, busy, done, pix_ready, win_valid, out_we, kernel_sel,
            out_filt, out_row[3:0], out_col[3:0], 4'd0};
  endfunction

  initial begin
    for (int i = 0; i < NRES; i++) begin
      expTab[i].f = 3'(i / 4);
      expTab[i].r = 8'((i % 4) / 2);
      expTab[i].c = 8'(i % 2);
    end

    repeat (2) @(negedge clk);
    checkOutput("resetState", allOutputs(), 0);
    checkOutput("resetRowCol", {16'd0, out_row, out_col}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // No stalls, with a stray start pulse in the middle of RUN.
    applyStimulus(1'b0, 1'b1, 0);
    checkRun("contig", 2 * (PIX + 4) + 1);
`ifdef CONV_SCHED_PERF_EN
    checkOutput("contig_perfCycles", perf_cycles, 81);
    checkOutput("contig_perfStall", perf_stall, 0);
`endif

    // A datapath result arriving in IDLE must not write or move the address.
    repeat (6) @(posedge clk);
    #1 inject = 1'b1;
    @(negedge clk);
    checkOutput("idleInject_outWe", {31'd0, out_we}, 0);
    @(posedge clk); #1 inject = 1'b0;
    @(negedge clk);
    checkOutput("idleInject_addr", {16'd0, out_row, out_col}, 0);
    checkOutput("idleInject_busy", {31'd0, busy}, 0);

    // Pixel valid every other cycle stretches RUN but not the results.
    applyStimulus(1'b1, 1'b0, 0);
    checkRun("toggle", 152);
`ifdef CONV_SCHED_PERF_EN
    checkOutput("toggle_perfCycles", perf_cycles, 152);
    checkOutput("toggle_perfStall", perf_stall, 71);
`endif

    // Reset asserted at the 20th transfer of the second pass.
    repeat (4) @(posedge clk);
    applyStimulus(1'b0, 1'b0, PIX + 4 + 20);
    checkOutput("midReset_outputs", allOutputs(), 0);
    checkOutput("midReset_rowCol", {16'd0, out_row, out_col}, 0);
    checkOutput("midReset_resBefore", resN, 4);
    @(posedge clk); #1 rst = 1'b0;
    repeat (8) @(posedge clk);

    applyStimulus(1'b0, 1'b0, 0);
    checkRun("afterReset", 2 * (PIX + 4) + 1);
`ifdef CONV_SCHED_PERF_EN
    checkOutput("afterReset_perfCycles", perf_cycles, 81);
    checkOutput("afterReset_perfStall", perf_stall, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
